// File: rtl/stopwatch_top_if.sv
// Control/readout bundle between the stopwatch core and whatever drives it.
// The master side issues run/clear commands and reads back the elapsed
// seconds and the once-per-second tick; the slave side is the stopwatch itself.
interface stopwatch_top_if #(
    parameter int SEC_W = 13
);
    logic             run;
    logic             clr;
    logic [SEC_W-1:0] seconds;
    logic             tick;

    modport master (
        output run,
        output clr,
        input  seconds,
        input  tick
    );

    modport slave (
        input  run,
        input  clr,
        output seconds,
        output tick
    );
endinterface

// File: rtl/stopwatch_top.sv
// Stopwatch: divides the system clock to a one-second tick and counts elapsed
// whole seconds. A prescaler counts clock edges while running and wraps at
// CLK_HZ-1; each wrap emits a one-cycle tick and advances the seconds counter,
// which rolls over to zero after its all-ones value. Pausing freezes both
// counters so a partial second survives, and clear zeroes everything and wins
// over a coincident increment. CLK_HZ must be at least 2.
module stopwatch_top #(
    parameter int CLK_HZ = 100_000_000,
    parameter int SEC_W  = 13
) (
    input  logic            clk,
    input  logic            rst_n,
    stopwatch_top_if.slave  bus
);

    localparam int               PRE_W    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

    logic [PRE_W-1:0] prescaler_q;
    logic [PRE_W-1:0] prescaler_d;
    logic [SEC_W-1:0] seconds_q;
    logic [SEC_W-1:0] seconds_d;
    logic             tick_q;
    logic             tick_d;
    logic             atLast;

    assign atLast = (prescaler_q == PRE_LAST);

    // Next-state logic: clear dominates, then counting while running, else hold.
    always_comb begin
        prescaler_d = prescaler_q;
        seconds_d   = seconds_q;
        tick_d      = 1'b0;
        if (bus.clr) begin
            prescaler_d = '0;
            seconds_d   = '0;
        end else if (bus.run) begin
            if (atLast) begin
                prescaler_d = '0;
                seconds_d   = seconds_q + SEC_W'(1);
                tick_d      = 1'b1;
            end else begin
                prescaler_d = prescaler_q + PRE_W'(1);
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            seconds_q   <= '0;
            tick_q      <= 1'b0;
        end else begin
            prescaler_q <= prescaler_d;
            seconds_q   <= seconds_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.seconds = seconds_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_stopwatch_top.sv
// Bench for stopwatch_top: a table of run/clear segments with hand-derived
// expectations, hand-written reset sequences, randomized run/clear traffic
// checked against an elapsed-edge model, and a rollover test on a second
// instance with a fast prescaler.
module tb_stopwatch_top;

    localparam int CLK_HZ  = 10;
    localparam int WRAP_HZ = 2;
    localparam int SEC_W   = 13;
    localparam int SEC_MOD = 1 << SEC_W;

    typedef struct {
        string name;
        bit    run;
        bit    clr;
        int    cycles;
        int    expSeconds;
        int    expTicks;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int     testsRun = 0;
    int     testsFailed = 0;
    longint elapsed = 0;
    bit     modelTick = 1'b0;
    int     tickCount = 0;
    vec_t   vecs[$];

    stopwatch_top_if #(.SEC_W(SEC_W)) swIf ();
    stopwatch_top_if #(.SEC_W(SEC_W)) wrapIf ();

    stopwatch_top #(.CLK_HZ(CLK_HZ), .SEC_W(SEC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (swIf.slave)
    );

    stopwatch_top #(.CLK_HZ(WRAP_HZ), .SEC_W(SEC_W)) dutWrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (wrapIf.slave)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference: seconds are whole multiples of CLK_HZ among the counted edges
    // since the last reset or clear, and a tick marks each such multiple.
    task automatic modelEdge();
        if (!rst_n || swIf.clr) begin
            elapsed   = 0;
            modelTick = 1'b0;
        end else if (swIf.run) begin
            elapsed   = elapsed + 1;
            modelTick = (elapsed % CLK_HZ) == 0;
        end else begin
            modelTick = 1'b0;
        end
    endtask

    function automatic int modelSeconds();
        return int'((elapsed / CLK_HZ) % SEC_MOD);
    endfunction

    task automatic applyStimulus(input bit run, input bit clr);
        swIf.run = run;
        swIf.clr = clr;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("cycleSeconds", 32'(swIf.seconds), 32'(modelSeconds()));
        checkOutput("cycleTick", 32'(swIf.tick), 32'(modelTick));
        if (swIf.tick === 1'b1) tickCount++;
    endtask

    initial begin
        swIf.run   = 1'b1;
        swIf.clr   = 1'b0;
        wrapIf.run = 1'b1;
        wrapIf.clr = 1'b1;
        rst_n      = 1'b0;

        // Held in reset with run asserted: nothing may move.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput("resetSeconds", 32'(swIf.seconds), 32'd0);
            checkOutput("resetTick", 32'(swIf.tick), 32'd0);
        end

        // First tick lands exactly CLK_HZ edges after release.
        @(negedge clk);
        rst_n = 1'b1;
        tickCount = 0;
        for (int i = 0; i < CLK_HZ - 1; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("preFirstTickSeconds", 32'(swIf.seconds), 32'd0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("firstTickSeconds", 32'(swIf.seconds), 32'd1);
        checkOutput("firstTickPulse", 32'(swIf.tick), 32'd1);
        checkOutput("firstTickCount", 32'(tickCount), 32'd1);

        // Asynchronous reset between edges takes effect before the next edge.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncResetSeconds", 32'(swIf.seconds), 32'd0);
        checkOutput("asyncResetTick", 32'(swIf.tick), 32'd0);
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Segment table, starting from a freshly released counter.
        vecs.push_back('{"freeRun25",    1'b1, 1'b0, 25, 2, 2});
        vecs.push_back('{"toPrescale6",  1'b1, 1'b0,  1, 2, 0});
        vecs.push_back('{"pause20",      1'b0, 1'b0, 20, 2, 0});
        vecs.push_back('{"resume3",      1'b1, 1'b0,  3, 2, 0});
        vecs.push_back('{"resume4th",    1'b1, 1'b0,  1, 3, 1});
        vecs.push_back('{"run9",         1'b1, 1'b0,  9, 3, 0});
        vecs.push_back('{"clrAtWrap",    1'b1, 1'b1,  1, 0, 0});
        vecs.push_back('{"postClr9",     1'b1, 1'b0,  9, 0, 0});
        vecs.push_back('{"postClr10th",  1'b1, 1'b0,  1, 1, 1});
        vecs.push_back('{"run5",         1'b1, 1'b0,  5, 1, 0});
        vecs.push_back('{"clrPaused",    1'b0, 1'b1,  1, 0, 0});
        vecs.push_back('{"pausedAfter",  1'b0, 1'b0,  4, 0, 0});
        vecs.push_back('{"run10",        1'b1, 1'b0, 10, 1, 1});
        foreach (vecs[k]) begin
            tickCount = 0;
            for (int c = 0; c < vecs[k].cycles; c++) applyStimulus(vecs[k].run, vecs[k].clr);
            checkOutput({vecs[k].name, "_seconds"}, 32'(swIf.seconds), 32'(vecs[k].expSeconds));
            checkOutput({vecs[k].name, "_ticks"}, 32'(tickCount), 32'(vecs[k].expTicks));
        end

        // Randomized run/clear traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
        end
        swIf.run = 1'b0;
        swIf.clr = 1'b0;

        // Rollover from the all-ones seconds value on the fast instance.
        @(negedge clk);
        wrapIf.clr = 1'b0;
        repeat ((SEC_MOD - 1) * WRAP_HZ) @(posedge clk);
        #1;
        checkOutput("wrapTopSeconds", 32'(wrapIf.seconds), 32'(SEC_MOD - 1));
        checkOutput("wrapTopTick", 32'(wrapIf.tick), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("wrapMidSeconds", 32'(wrapIf.seconds), 32'(SEC_MOD - 1));
        checkOutput("wrapMidTick", 32'(wrapIf.tick), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("wrapZeroSeconds", 32'(wrapIf.seconds), 32'd0);
        checkOutput("wrapZeroTick", 32'(wrapIf.tick), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("wrapAfterTick", 32'(wrapIf.tick), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
